// File: rtl/zmem_arbiter.sv
// Round-robin arbiter giving the zephyr core sequencer and the loader/debug port
// turns on the single-port ram: one registered access per REQ/ACK handshake.
module zmem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              C_REQ,
    input  logic              C_WE,
    input  logic [ADDR_W-1:0] C_ADDR,
    input  logic [DATA_W-1:0] C_WDATA,
    output logic              C_ACK,
    output logic [DATA_W-1:0] C_RDATA,
    input  logic              L_REQ,
    input  logic              L_WE,
    input  logic [ADDR_W-1:0] L_ADDR,
    input  logic [DATA_W-1:0] L_WDATA,
    output logic              L_ACK,
    output logic [DATA_W-1:0] L_RDATA,
    input  logic              L_LOCK,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic              RAM_OP,
    output logic [DATA_W-1:0] RAM_DATA_IN,
    input  logic [DATA_W-1:0] RAM_DATA_OUT,
    output logic              BUSY,
    output logic              OWNER
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic [ADDR_W-1:0]  w_ram_addr_nxt;
    logic               r_ram_op;
    logic               w_ram_op_nxt;
    logic [DATA_W-1:0]  r_ram_din;
    logic [DATA_W-1:0]  w_ram_din_nxt;
    logic [DATA_W-1:0]  r_c_rdata;
    logic [DATA_W-1:0]  w_c_rdata_nxt;
    logic [DATA_W-1:0]  r_l_rdata;
    logic [DATA_W-1:0]  w_l_rdata_nxt;
    logic               r_c_ack;
    logic               w_c_ack_nxt;
    logic               r_l_ack;
    logic               w_l_ack_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_owner;
    logic               w_owner_nxt;

    logic               w_c_elig;
    logic               w_l_elig;
    logic               w_grant;
    logic               w_winner;

    // Eligibility and round-robin winner selection (1 = loader)
    always_comb begin
        w_c_elig = C_REQ & ~L_LOCK;
        w_l_elig = L_REQ;
        w_grant  = w_c_elig | w_l_elig;
        if (w_c_elig && w_l_elig) begin
            w_winner = ~r_owner;
        end else begin
            w_winner = w_l_elig;
        end
    end

    // Next-state and next-output logic; RAM_OP and the ACKs default low so
    // each can only be high for the single cycle that sets it
    always_comb begin
        w_state_nxt    = r_state;
        w_ram_addr_nxt = r_ram_addr;
        w_ram_op_nxt   = 1'b0;
        w_ram_din_nxt  = r_ram_din;
        w_c_rdata_nxt  = r_c_rdata;
        w_l_rdata_nxt  = r_l_rdata;
        w_c_ack_nxt    = 1'b0;
        w_l_ack_nxt    = 1'b0;
        w_busy_nxt     = r_busy;
        w_owner_nxt    = r_owner;

        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    if (w_winner) begin
                        w_ram_addr_nxt = L_ADDR;
                        w_ram_op_nxt   = L_WE;
                        w_ram_din_nxt  = L_WDATA;
                    end else begin
                        w_ram_addr_nxt = C_ADDR;
                        w_ram_op_nxt   = C_WE;
                        w_ram_din_nxt  = C_WDATA;
                    end
                    w_owner_nxt = w_winner;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_ACCESS;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_ACCESS: begin
                // r_ram_op still holds the granted WE during this cycle
                if (!r_ram_op) begin
                    if (r_owner) begin
                        w_l_rdata_nxt = RAM_DATA_OUT;
                    end else begin
                        w_c_rdata_nxt = RAM_DATA_OUT;
                    end
                end else begin
                    w_c_rdata_nxt = r_c_rdata;
                end
                if (r_owner) begin
                    w_l_ack_nxt = 1'b1;
                end else begin
                    w_c_ack_nxt = 1'b1;
                end
                w_state_nxt = S_DONE;
            end

            S_DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_ram_addr <= {ADDR_W{1'b0}};
            r_ram_op   <= 1'b0;
            r_ram_din  <= {DATA_W{1'b0}};
            r_c_rdata  <= {DATA_W{1'b0}};
            r_l_rdata  <= {DATA_W{1'b0}};
            r_c_ack    <= 1'b0;
            r_l_ack    <= 1'b0;
            r_busy     <= 1'b0;
            r_owner    <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_ram_addr <= w_ram_addr_nxt;
            r_ram_op   <= w_ram_op_nxt;
            r_ram_din  <= w_ram_din_nxt;
            r_c_rdata  <= w_c_rdata_nxt;
            r_l_rdata  <= w_l_rdata_nxt;
            r_c_ack    <= w_c_ack_nxt;
            r_l_ack    <= w_l_ack_nxt;
            r_busy     <= w_busy_nxt;
            r_owner    <= w_owner_nxt;
        end
    end

    assign RAM_ADDR    = r_ram_addr;
    assign RAM_OP      = r_ram_op;
    assign RAM_DATA_IN = r_ram_din;
    assign C_RDATA     = r_c_rdata;
    assign L_RDATA     = r_l_rdata;
    assign C_ACK       = r_c_ack;
    assign L_ACK       = r_l_ack;
    assign BUSY        = r_busy;
    assign OWNER       = r_owner;

endmodule

// File: doc/zmem_arbiter.md
# zmem_arbiter

Two-requester arbiter sharing the single-port `ram` instance between the `zephyr` core's memory sequencer and a program loader/debug port. Each requester issues one registered read or write per request/acknowledge handshake. The arbiter grants round-robin, drives the RAM control registers, captures read data and returns a one-cycle acknowledge. A loader lock input can hold the core off the RAM during program download.

## Interface
- `ADDR_W`, 4, RAM address width; matches the 16-entry `ram`.
- `DATA_W`, 8, RAM data width.

- `CLK`  in  1  clock. Everything in this block is sampled on its rising edge.
- `RESET`  in  1  synchronous, active-high reset. It is sampled on the `CLK` rising edge.
- `C_REQ`  in  1  core request. Held with `C_WE`/`C_ADDR`/`C_WDATA` stable until `C_ACK`.
- `C_WE`  in  1  core access type: 1 = write, 0 = read.
- `C_ADDR`  in  ADDR_W  core address.
- `C_WDATA`  in  DATA_W  core write data.
- `C_ACK`  out  1  one-cycle completion pulse to the core.
- `C_RDATA`  out  DATA_W  core read data. Valid from `C_ACK` and held until the next core read completes.
- `L_REQ`, `L_WE`, `L_ADDR`, `L_WDATA`, `L_ACK`, `L_RDATA`  loader port. Same widths and rules as the core port.
- `L_LOCK`  in  1  when high, no new core grants are issued. An in-flight core access completes normally.
- `RAM_ADDR`  out  ADDR_W  to `ram.ADDRESS`.
- `RAM_OP`  out  1  to `ram.OPCODE`: 1 = write.
- `RAM_DATA_IN`  out  DATA_W  to `ram.DATA_IN`.
- `RAM_DATA_OUT`  in  DATA_W  from `ram.DATA_OUT`. Combinational read of `RAM_ADDR`.
- `BUSY`  out  1  high whenever the FSM is not in IDLE.
- `OWNER`  out  1  requester of the current or last access: 0 = core, 1 = loader.

## Operation
- All outputs are registered.
- Reset values:
  - State: IDLE.
  - `RAM_ADDR`, `RAM_DATA_IN`, `C_RDATA`, `L_RDATA`: 0.
  - `RAM_OP`, `C_ACK`, `L_ACK`, `BUSY`: 0.
  - `OWNER`: 1, so the core wins the first tie.
- FSM states are IDLE, ACCESS and DONE.
- IDLE:
  - The eligible core request is `C_REQ & ~L_LOCK`. The eligible loader request is `L_REQ`.
  - If exactly one request is eligible, grant it.
  - If both are eligible, grant the requester that is not `OWNER` (round-robin).
  - On a grant: load `RAM_ADDR`, `RAM_OP` (= WE) and `RAM_DATA_IN` from the winner; set `OWNER` to the winner; set `BUSY`=1; go to ACCESS.
  - With no eligible request, stay in IDLE and leave the RAM registers unchanged except `RAM_OP`, which stays 0.
- ACCESS:
  - The RAM sees a stable address, op and data for the whole cycle. A write is performed by the `ram` at the end of this cycle.
  - On a read: capture `RAM_DATA_OUT` into the owner's RDATA. The other requester's RDATA is untouched.
  - On a write: both RDATA registers are unchanged.
  - Set `RAM_OP`=0, pulse the owner's ACK, go to DONE.
- DONE:
  - Clear ACK, set `BUSY`=0, go to IDLE.
  - Requests are not sampled in DONE.
- Requester rules:
  - Deassert REQ in the cycle after ACK, or keep it high to request another access.
  - A REQ still high in IDLE is a new request.
- Changing WE/ADDR/WDATA while REQ is pending is illegal. The arbiter uses the values sampled at the grant edge.
- `L_LOCK` only gates core grants. It has no effect on the loader or on accesses already in flight.
- Reset mid-access: the synchronous reset edge returns every output to its reset value. `RAM_OP` falls in the same edge, so no write is issued after reset. No ACK is produced for an aborted access.

## Timing
- Grant: request sampled in IDLE at edge N, so RAM registers are valid after edge N.
- Completion: ACK high and RDATA valid after edge N+1, for exactly one cycle.
- FSM back to IDLE after edge N+2. The next grant can occur at edge N+3.
- Peak throughput is one access per 3 cycles. Under continuous contention the two requesters strictly alternate.
- Worst-case wait for an unlocked requester is one competing access: 3 cycles plus its own 3.
- `RAM_OP` is high for exactly one cycle per write and never for reads.

## Test plan
- Reset, then a core read of addr 5 (RAM[5]=0x3C) -> `RAM_ADDR`=5 and `RAM_OP`=0 one cycle after grant; `C_ACK` for one cycle with `C_RDATA`=0x3C; `L_ACK` stays 0.
- Loader write 0xA7 to addr 9, then core read of addr 9 -> `RAM_OP` high for one cycle, `L_RDATA` unchanged, core reads 0xA7.
- Both request continuously from reset, core reads addr 1, loader reads addr 2 -> grants ordered C,L,C,L with an ACK every 3 cycles; `OWNER` toggles each grant.
- `L_LOCK`=1 with `C_REQ` held for 10 cycles while the loader performs 3 writes -> no `C_ACK` while locked; the core is granted at the first IDLE after `L_LOCK` falls.
- Assert `RESET` in the ACCESS cycle of a loader write -> `RAM_OP`=0 and all outputs at reset values after that edge; no `L_ACK`; a subsequent core request completes normally.
- Core read, then core write to the same address back-to-back with `C_REQ` held high -> second grant 3 cycles after the first; `C_RDATA` holds the read value through the write.
